// File: rtl/iob_split_pkg.sv
// Shared constants and helpers for the pipelined IOb bus split.
package iob_split_pkg;

  localparam int ERR_UNMAPPED = 0;
  localparam int ERR_SPURIOUS = 1;

  // Wide enough for any sensible data bus; users take the low DATA_W bits.
  localparam int ERR_RDATA_MAXW = 1024;
  localparam logic [ERR_RDATA_MAXW-1:0] ERR_RDATA = '1;

  function automatic int sel_width(input int n_slaves);
    return (n_slaves > 1) ? $clog2(n_slaves) : 1;
  endfunction

endpackage

// File: rtl/iob_split_track_fifo.sv
// Small FIFO of target indices for outstanding reads; head is the target
// whose read data must come back next.
module iob_split_track_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/iob_split_pipe.sv
// IOb 1:N bus split with in-order tracking of outstanding reads and an
// internal error responder for unmapped select values.
module iob_split_pipe
  import iob_split_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_SLAVES  = 4,
  parameter int SEL_MSB   = ADDR_W - 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_avalid,
  input  logic [ADDR_W-1:0]                m_addr,
  input  logic [DATA_W-1:0]                m_wdata,
  input  logic [DATA_W/8-1:0]              m_wstrb,
  output logic                             m_ready,
  output logic                             m_rvalid,
  output logic [DATA_W-1:0]                m_rdata,
  output logic [N_SLAVES-1:0]              s_avalid,
  output logic [N_SLAVES*ADDR_W-1:0]       s_addr,
  output logic [N_SLAVES*DATA_W-1:0]       s_wdata,
  output logic [N_SLAVES*(DATA_W/8)-1:0]   s_wstrb,
  input  logic [N_SLAVES-1:0]              s_ready,
  input  logic [N_SLAVES-1:0]              s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0]       s_rdata,
  input  logic                             err_clr,
  output logic [1:0]                       err
);

  localparam int SEL_W = sel_width(N_SLAVES);
  localparam int IDX_W = $clog2(N_SLAVES + 1);

  logic [SEL_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_tgt;
  logic [IDX_W-1:0]  w_head;
  logic              w_unmapped;
  logic              w_is_rd;
  logic              w_stall;
  logic              w_full;
  logic              w_empty;
  logic              w_tgt_ready;
  logic              w_head_rvalid;
  logic [DATA_W-1:0] w_head_rdata;
  logic              w_spur;
  logic              w_acc;
  logic              w_push;
  logic [1:0]        w_err_set;

  logic [IDX_W-1:0]  r_last_sel;
  logic              r_err_pend;
  logic [1:0]        r_err;

  assign w_sel      = m_addr[SEL_MSB -: SEL_W];
  assign w_tgt      = (32'(w_sel) >= N_SLAVES) ? IDX_W'(N_SLAVES) : IDX_W'(w_sel);
  assign w_unmapped = (w_tgt == IDX_W'(N_SLAVES));
  assign w_is_rd    = (m_wstrb == '0);

  // Stall uses registered occupancy only, so a same-cycle return never unblocks.
  assign w_stall = w_is_rd & (w_full | (~w_empty & (w_tgt != r_last_sel)));

  always_comb begin
    w_tgt_ready   = 1'b0;
    w_head_rvalid = 1'b0;
    w_head_rdata  = '0;
    w_spur        = 1'b0;
    s_avalid      = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_tgt == IDX_W'(i)) w_tgt_ready = s_ready[i];
      if (w_head == IDX_W'(i)) begin
        w_head_rvalid = s_rvalid[i];
        w_head_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
      if (s_rvalid[i] && (w_empty || (w_head != IDX_W'(i)))) w_spur = 1'b1;
      s_avalid[i] = rst & m_avalid & ~w_stall & (w_tgt == IDX_W'(i));
    end
    if (w_unmapped) w_tgt_ready = 1'b1;
    if (w_head == IDX_W'(N_SLAVES)) begin
      w_head_rvalid = r_err_pend;
      w_head_rdata  = ERR_RDATA[DATA_W-1:0];
    end
  end

  assign m_ready  = rst & ~w_stall & w_tgt_ready;
  assign m_rvalid = rst & ~w_empty & w_head_rvalid;
  assign m_rdata  = w_head_rdata;

  assign s_addr  = {N_SLAVES{m_addr}};
  assign s_wdata = {N_SLAVES{m_wdata}};
  assign s_wstrb = {N_SLAVES{m_wstrb}};

  assign w_acc  = m_avalid & m_ready;
  assign w_push = w_acc & w_is_rd;

  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_UNMAPPED] = w_acc & w_unmapped;
    w_err_set[ERR_SPURIOUS] = w_spur;
  end

  iob_split_track_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_track (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (w_tgt),
    .i_pop   (m_rvalid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_sel <= '0;
      r_err_pend <= 1'b0;
      r_err      <= '0;
    end else begin
      if (w_push) r_last_sel <= w_tgt;
      r_err_pend <= w_push & w_unmapped;
      r_err      <= (r_err & ~{2{err_clr}}) | w_err_set;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_iob_split_pipe.sv
// Directed bench for iob_split_pipe: a 4-slave instance driven from a vector
// table plus hand sequences, and a 3-slave instance for the error responder.
module tb_iob_split_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // 4-slave instance
  logic         a_m_avalid, a_m_ready, a_m_rvalid, a_err_clr;
  logic [31:0]  a_m_addr, a_m_wdata, a_m_rdata;
  logic [3:0]   a_m_wstrb;
  logic [3:0]   a_s_avalid, a_s_ready, a_s_rvalid;
  logic [127:0] a_s_addr, a_s_wdata, a_s_rdata;
  logic [15:0]  a_s_wstrb;
  logic [1:0]   a_err;

  // 3-slave instance
  logic         b_m_avalid, b_m_ready, b_m_rvalid, b_err_clr;
  logic [31:0]  b_m_addr, b_m_wdata, b_m_rdata;
  logic [3:0]   b_m_wstrb;
  logic [2:0]   b_s_avalid, b_s_ready, b_s_rvalid;
  logic [95:0]  b_s_addr, b_s_wdata, b_s_rdata;
  logic [11:0]  b_s_wstrb;
  logic [1:0]   b_err;

  iob_split_pipe #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4), .SEL_MSB(31), .MAX_OUTST(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .m_avalid(a_m_avalid), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
    .m_ready(a_m_ready), .m_rvalid(a_m_rvalid), .m_rdata(a_m_rdata),
    .s_avalid(a_s_avalid), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
    .s_ready(a_s_ready), .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata),
    .err_clr(a_err_clr), .err(a_err)
  );

  iob_split_pipe #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .SEL_MSB(31), .MAX_OUTST(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .m_avalid(b_m_avalid), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_ready(b_m_ready), .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata),
    .s_avalid(b_s_avalid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
    .s_ready(b_s_ready), .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata),
    .err_clr(b_err_clr), .err(b_err)
  );

  typedef struct {
    logic        av;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic        clr;
    logic        e_rdy;
    logic [3:0]  e_sav;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_m_avalid = 1'b1; a_m_addr = '0; a_m_wdata = 32'h1234_5678; a_m_wstrb = '0;
    a_s_ready = 4'hF; a_s_rvalid = 4'hF; a_err_clr = 1'b0;
    a_s_rdata = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};
    b_m_avalid = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_m_wstrb = '0;
    b_s_ready = 3'b111; b_s_rvalid = '0; b_err_clr = 1'b0;
    b_s_rdata = {32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

    // {av, addr, wstrb, rdy, rv, clr, e_rdy, e_sav, e_rv, e_rdata, e_err}
    vt[0]  = '{1'b0, 32'h0000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b00};
    vt[1]  = '{1'b1, 32'h0000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0, 2'b00};
    vt[2]  = '{1'b1, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 2'b00};
    vt[3]  = '{1'b1, 32'h8000_0000, 4'h0, 4'hF, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hD0D0_0000, 2'b00};
    vt[4]  = '{1'b1, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0, 2'b00};
    vt[5]  = '{1'b1, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0, 2'b00};
    vt[6]  = '{1'b1, 32'hC000_0000, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h0, 2'b00};
    vt[7]  = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hD0D0_0002, 2'b00};
    vt[8]  = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hD0D0_0002, 2'b00};
    vt[9]  = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b00};
    vt[10] = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b10};
    vt[11] = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b10};
    vt[12] = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b00};
    vt[13] = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b00};
    vt[14] = '{1'b0, 32'h8000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'b10};
    vt[15] = '{1'b1, 32'h4000_0000, 4'h0, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0, 2'b10};
    vt[16] = '{1'b1, 32'h4000_0000, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0, 2'b10};
    vt[17] = '{1'b0, 32'h4000_0000, 4'h0, 4'hF, 4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hD0D0_0001, 2'b10};

    // Reset state: request and response paths held off
    #2;
    chk("rst_m_ready", 0, 32'(a_m_ready), 32'd0);
    chk("rst_s_avalid", 0, 32'(a_s_avalid), 32'd0);
    chk("rst_m_rvalid", 0, 32'(a_m_rvalid), 32'd0);
    chk("rst_err_a", 0, 32'(a_err), 32'd0);
    chk("rst_err_b", 0, 32'(b_err), 32'd0);
    a_m_avalid = 1'b0; a_s_rvalid = '0;
    #21 rst = 1'b1;
    next_cyc();

    // 3-slave instance: unmapped read then unmapped write
    b_m_avalid = 1'b1; b_m_addr = 32'hC000_0010; b_m_wstrb = 4'h0;
    #1;
    chk("b_rd_ready", 0, 32'(b_m_ready), 32'd1);
    chk("b_rd_savalid", 0, 32'(b_s_avalid), 32'd0);
    chk("b_rd_rvalid0", 0, 32'(b_m_rvalid), 32'd0);
    next_cyc();
    b_m_avalid = 1'b0;
    #1;
    chk("b_rd_rvalid1", 0, 32'(b_m_rvalid), 32'd1);
    chk("b_rd_rdata", 0, b_m_rdata, 32'hFFFF_FFFF);
    chk("b_rd_err", 0, 32'(b_err), 32'd1);
    next_cyc();
    b_m_avalid = 1'b1; b_m_wstrb = 4'hF;
    #1;
    chk("b_wr_ready", 0, 32'(b_m_ready), 32'd1);
    next_cyc();
    b_m_avalid = 1'b0; b_m_wstrb = 4'h0;
    #1;
    chk("b_wr_no_rvalid", 0, 32'(b_m_rvalid), 32'd0);
    next_cyc();

    // Vector table on the 4-slave instance
    for (int k = 0; k < NV; k++) begin
      a_m_avalid = vt[k].av;  a_m_addr = vt[k].addr; a_m_wstrb = vt[k].wstrb;
      a_s_ready  = vt[k].rdy; a_s_rvalid = vt[k].rv; a_err_clr = vt[k].clr;
      #1;
      chk("vec_m_ready", k, 32'(a_m_ready), 32'(vt[k].e_rdy));
      chk("vec_s_avalid", k, 32'(a_s_avalid), 32'(vt[k].e_sav));
      chk("vec_m_rvalid", k, 32'(a_m_rvalid), 32'(vt[k].e_rv));
      chk("vec_err", k, 32'(a_err), 32'(vt[k].e_err));
      if (vt[k].e_rv) chk("vec_m_rdata", k, a_m_rdata, vt[k].e_rdata);
      next_cyc();
    end
    a_m_avalid = 1'b0; a_s_rvalid = '0; a_s_ready = 4'hF; a_err_clr = 1'b1;
    next_cyc();
    a_err_clr = 1'b0;
    #1;
    chk("clr_before_burst", 0, 32'(a_err), 32'd0);
    next_cyc();

    // Five back-to-back reads to slave 1, responses starting after the stall
    a_m_addr = 32'h4000_0000; a_m_wstrb = 4'h0;
    for (int k = 0; k <= 10; k++) begin
      a_m_avalid = (k <= 6);
      a_s_rvalid = (k >= 5 && k <= 9) ? 4'b0010 : 4'b0000;
      a_s_rdata[63:32] = 32'h5100_0000 + 32'(k - 5);
      #1;
      if (k <= 3) begin
        chk("burst_ready", k, 32'(a_m_ready), 32'd1);
        chk("burst_savalid", k, 32'(a_s_avalid), 32'b0010);
      end else if (k == 4 || k == 5) begin
        chk("burst_stall_ready", k, 32'(a_m_ready), 32'd0);
        chk("burst_stall_savalid", k, 32'(a_s_avalid), 32'd0);
      end else if (k == 6) begin
        chk("burst_fifth_ready", k, 32'(a_m_ready), 32'd1);
      end
      if (k >= 5 && k <= 9) begin
        chk("burst_rvalid", k, 32'(a_m_rvalid), 32'd1);
        chk("burst_rdata", k, a_m_rdata, 32'h5100_0000 + 32'(k - 5));
      end else begin
        chk("burst_no_rvalid", k, 32'(a_m_rvalid), 32'd0);
      end
      if (k == 6) begin
        next_cyc();
        a_m_avalid = 1'b0;
      end else begin
        next_cyc();
      end
    end
    a_s_rvalid = '0;
    #1;
    chk("burst_err", 0, 32'(a_err), 32'd0);
    next_cyc();

    // Reset with three reads outstanding
    a_s_rdata[63:32] = 32'hD0D0_0001;
    a_m_addr = 32'h4000_0000; a_m_avalid = 1'b1;
    for (int k = 0; k < 3; k++) next_cyc();
    #1;
    chk("pre_rst_ready", 0, 32'(a_m_ready), 32'd1);
    chk("pre_rst_savalid", 0, 32'(a_s_avalid), 32'b0010);
    #2 rst = 1'b0;
    a_s_rvalid = 4'b0010;
    #1;
    chk("async_rst_ready", 0, 32'(a_m_ready), 32'd0);
    chk("async_rst_savalid", 0, 32'(a_s_avalid), 32'd0);
    chk("async_rst_rvalid", 0, 32'(a_m_rvalid), 32'd0);
    a_m_avalid = 1'b0; a_s_rvalid = '0;
    #2 rst = 1'b1;
    next_cyc();
    chk("post_rst_err", 0, 32'(a_err), 32'd0);
    a_s_rvalid = 4'b0010;
    #1;
    chk("late_rvalid", 0, 32'(a_m_rvalid), 32'd0);
    next_cyc();
    a_s_rvalid = '0;
    a_m_avalid = 1'b1; a_m_addr = 32'h8000_0000;
    #1;
    chk("late_err", 0, 32'(a_err), 32'b10);
    chk("post_rst_ready", 0, 32'(a_m_ready), 32'd1);
    chk("post_rst_savalid", 0, 32'(a_s_avalid), 32'b0100);
    next_cyc();
    a_m_avalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
